// File: rtl/ransac_vjtag_pkg.sv
// Shared types and constants for the virtual JTAG host.
// State enum, debug-module IR codes and default scan widths.
package ransac_vjtag_pkg;

  localparam int DEF_DR_W = 38;
  localparam int DEF_IR_W = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_RSP
  } vj_state_t;

endpackage

// File: rtl/ransac_vjtag_tck_gen.sv
// TCK divider: low phase then high phase, TCK_DIV clks each.
// Ports: clk, reset, en in; tck, tck_rise, tck_fall out.
module ransac_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int TW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [TW-1:0] cnt;
  logic          run;
  logic          wrap;

  assign wrap     = run && (cnt == TW'(TCK_DIV - 1));
  assign tck_rise = en && wrap && !tck;
  // The first enabled clk opens a low phase.
  assign tck_fall = en && (!run || (wrap && tck));

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      run <= 1'b0;
      tck <= 1'b0;
      cnt <= '0;
    end else if (!run) begin
      run <= 1'b1;
      tck <= 1'b0;
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ransac_vjtag_host.sv
// Virtual JTAG initiator: one IR+DR scan per command.
// Ports: cmd/rsp handshakes, vj_* scan pins and strobes.
module ransac_vjtag_host
  import ransac_vjtag_pkg::*;
#(
  parameter int DR_W       = DEF_DR_W,
  parameter int IR_W       = DEF_IR_W,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_data,
  output logic            vj_tck,
  output logic            vj_tdi,
  input  logic            vj_tdo,
  output logic [IR_W-1:0] vj_ir_in,
  output logic            vj_uir,
  output logic            vj_cdr,
  output logic            vj_sdr,
  output logic            vj_udr,
  output logic            vj_rti
);

  localparam int MAXP = (DR_W > RTI_CYCLES) ? DR_W : RTI_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;

  vj_state_t       state, state_n;
  logic            pend, pend_n;
  logic [CW-1:0]   pcnt, pcnt_n;
  logic [DR_W-1:0] sr, sr_n;
  logic            tdi, tdi_n;
  logic [IR_W-1:0] ir, ir_n;
  logic            tck_en;
  logic            tck_rise;
  logic            tck_fall;

  // pend covers the clk between accept and the first low phase.
  assign cmd_ready = (state == S_IDLE) && !pend;
  assign rsp_valid = (state == S_RSP);
  assign rsp_data  = sr;
  assign vj_tdi    = tdi;
  assign vj_ir_in  = ir;
  assign vj_uir    = (state == S_UIR);
  assign vj_cdr    = (state == S_CDR);
  assign vj_sdr    = (state == S_SDR);
  assign vj_udr    = (state == S_UDR);
  assign vj_rti    = (state == S_RTI);
  assign tck_en    = pend || ((state != S_IDLE) && (state != S_RSP));

  ransac_vjtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck (
    .clk      (clk),
    .reset    (reset),
    .en       (tck_en),
    .tck      (vj_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pend  <= 1'b0;
      pcnt  <= '0;
      sr    <= '0;
      tdi   <= 1'b0;
      ir    <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      pcnt  <= pcnt_n;
      sr    <= sr_n;
      tdi   <= tdi_n;
      ir    <= ir_n;
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
    pcnt_n  = pcnt;
    sr_n    = sr;
    tdi_n   = tdi;
    ir_n    = ir;
    if (cmd_valid && cmd_ready) begin
      pend_n = 1'b1;
      ir_n   = cmd_ir;
      sr_n   = cmd_data;
    end
    // tdo is taken before the target's own rise update.
    if (tck_rise && state == S_SDR)
      sr_n = DR_W'({vj_tdo, sr} >> 1);
    if (tck_fall) begin
      unique case (state)
        S_IDLE: begin
          state_n = S_UIR;
          pend_n  = 1'b0;
        end
        S_UIR: state_n = S_CDR;
        S_CDR: begin
          state_n = S_SDR;
          pcnt_n  = '0;
          tdi_n   = sr[0];
        end
        S_SDR: begin
          if (pcnt == CW'(DR_W - 1)) begin
            state_n = S_UDR;
            tdi_n   = 1'b0;
          end else begin
            pcnt_n = pcnt + 1'b1;
            tdi_n  = sr[0];
          end
        end
        S_UDR: begin
          state_n = S_RTI;
          pcnt_n  = '0;
        end
        S_RTI: begin
          if (pcnt == CW'(RTI_CYCLES - 1))
            state_n = S_RSP;
          else
            pcnt_n = pcnt + 1'b1;
        end
        default: ;
      endcase
    end
    if (state == S_RSP && rsp_ready)
      state_n = S_IDLE;
  end

endmodule

// File: tb/tb_ransac_vjtag_host.sv
// Bench for ransac_vjtag_host: loopback target, timing,
// strobe sequencing, back-to-back, abort and DR_W=1 cases.
module tb_ransac_vjtag_host;

  localparam int A_LAT = 1 + 2 * 2 * (38 + 3 + 2);
  localparam int B_DIV = 1;

  int n_chk = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A: defaults
  logic        a_cmd_valid = 0, a_cmd_ready;
  logic [1:0]  a_cmd_ir = 0;
  logic [37:0] a_cmd_data = 0;
  logic        a_rsp_valid, a_rsp_ready = 0;
  logic [37:0] a_rsp_data;
  logic        a_tck, a_tdi, a_tdo;
  logic [1:0]  a_ir;
  logic        a_uir, a_cdr, a_sdr, a_udr, a_rti;

  // DUT B: TCK_DIV=1
  logic        b_cmd_valid = 0, b_cmd_ready;
  logic [1:0]  b_cmd_ir = 0;
  logic [37:0] b_cmd_data = 0;
  logic        b_rsp_valid, b_rsp_ready = 0;
  logic [37:0] b_rsp_data;
  logic        b_tck, b_tdi;
  logic        b_tdo = 1'b0;
  logic [1:0]  b_ir;
  logic        b_uir, b_cdr, b_sdr, b_udr, b_rti;

  // DUT C: DR_W=1, TCK_DIV=3, RTI_CYCLES=1
  logic        c_cmd_valid = 0, c_cmd_ready;
  logic [1:0]  c_cmd_ir = 0;
  logic [0:0]  c_cmd_data = 0;
  logic        c_rsp_valid, c_rsp_ready = 0;
  logic [0:0]  c_rsp_data;
  logic        c_tck, c_tdi;
  logic        c_tdo = 1'b1;
  logic [1:0]  c_ir;
  logic        c_uir, c_cdr, c_sdr, c_udr, c_rti;

  ransac_vjtag_host u_a (
    .clk(clk), .reset(reset),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_ir(a_cmd_ir), .cmd_data(a_cmd_data),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_data(a_rsp_data),
    .vj_tck(a_tck), .vj_tdi(a_tdi), .vj_tdo(a_tdo),
    .vj_ir_in(a_ir),
    .vj_uir(a_uir), .vj_cdr(a_cdr), .vj_sdr(a_sdr),
    .vj_udr(a_udr), .vj_rti(a_rti)
  );

  ransac_vjtag_host #(.TCK_DIV(B_DIV)) u_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data),
    .vj_tck(b_tck), .vj_tdi(b_tdi), .vj_tdo(b_tdo),
    .vj_ir_in(b_ir),
    .vj_uir(b_uir), .vj_cdr(b_cdr), .vj_sdr(b_sdr),
    .vj_udr(b_udr), .vj_rti(b_rti)
  );

  ransac_vjtag_host #(
    .DR_W(1), .TCK_DIV(3), .RTI_CYCLES(1)
  ) u_c (
    .clk(clk), .reset(reset),
    .cmd_valid(c_cmd_valid), .cmd_ready(c_cmd_ready),
    .cmd_ir(c_cmd_ir), .cmd_data(c_cmd_data),
    .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
    .rsp_data(c_rsp_data),
    .vj_tck(c_tck), .vj_tdi(c_tdi), .vj_tdo(c_tdo),
    .vj_ir_in(c_ir),
    .vj_uir(c_uir), .vj_cdr(c_cdr), .vj_sdr(c_sdr),
    .vj_udr(c_udr), .vj_rti(c_rti)
  );

  // Target model: 38-bit DR shifting on tck rise while in SDR.
  logic [37:0] tgt;
  logic [37:0] tgt_pre = 0;
  logic        tgt_ld = 0;
  logic        a_tck_q = 0;
  assign a_tdo = tgt[0];
  always @(posedge clk) begin
    a_tck_q <= a_tck;
    if (tgt_ld)
      tgt <= tgt_pre;
    else if (a_tck && !a_tck_q && a_sdr)
      tgt <= {a_tdi, tgt[37:1]};
  end

  task automatic load_tgt(input logic [37:0] v);
    @(negedge clk);
    tgt_pre = v;
    tgt_ld = 1'b1;
    @(negedge clk);
    tgt_ld = 1'b0;
  endtask

  task automatic a_run(input logic [1:0] ir,
                       input logic [37:0] d,
                       output int lat);
    @(negedge clk);
    a_cmd_ir = ir;
    a_cmd_data = d;
    a_cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_cmd_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!a_rsp_valid) lat = -1;
  endtask

  task automatic a_ack();
    @(negedge clk);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  function automatic logic [37:0] rnd38();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  task automatic test_reset();
    logic [4:0] s;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    s = {a_uir, a_cdr, a_sdr, a_udr, a_rti};
    n_chk++;
    if (a_tck !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tck got %b want 0", a_tck);
    end
    n_chk++;
    if (a_tdi !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tdi got %b want 0", a_tdi);
    end
    n_chk++;
    if (a_ir !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ir got %0d want 0", a_ir);
    end
    n_chk++;
    if (s !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 00000", s);
    end
    n_chk++;
    if (a_rsp_valid !== 1'b0 || a_rsp_data !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_rsp got v=%b d=%h want 0/0",
               a_rsp_valid, a_rsp_data);
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (a_cmd_ready !== 1'b1 || c_cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got a=%b c=%b want 1",
               a_cmd_ready, c_cmd_ready);
    end
  endtask

  task automatic test_scan();
    logic [37:0] d, p;
    logic [1:0]  ir;
    int lat;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        d = 38'h2_AAAA_5555;
        p = 38'h1_2345_6789;
        ir = 2'd2;
      end else begin
        d = rnd38();
        p = rnd38();
        ir = 2'($urandom_range(3));
      end
      load_tgt(p);
      a_run(ir, d, lat);
      n_chk++;
      if (lat != A_LAT) begin
        n_fail++;
        $display("FAIL scan%0d_latency got %0d want %0d",
                 i, lat, A_LAT);
      end
      n_chk++;
      if (a_rsp_data !== p) begin
        n_fail++;
        $display("FAIL scan%0d_rsp got %h want %h",
                 i, a_rsp_data, p);
      end
      n_chk++;
      if (tgt !== d) begin
        n_fail++;
        $display("FAIL scan%0d_target got %h want %h", i, tgt, d);
      end
      n_chk++;
      if (a_ir !== ir || a_tck !== 1'b0) begin
        n_fail++;
        $display("FAIL scan%0d_ir_tck got %0d/%b want %0d/0",
                 i, a_ir, a_tck, ir);
      end
      a_ack();
      n_chk++;
      if (a_rsp_valid !== 1'b0 || a_cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL scan%0d_ack got v=%b r=%b want 0/1",
                 i, a_rsp_valid, a_cmd_ready);
      end
    end
  endtask

  task automatic test_strobes();
    int exp_code[$];
    int exp_len[$];
    int obs_code[$];
    int obs_len[$];
    int cur, run, k, code;
    bit multi, irbad;
    exp_code = '{0, 16, 8, 4, 2, 1};
    exp_len = '{1, 2*B_DIV, 2*B_DIV, 2*B_DIV*38,
                2*B_DIV, 2*B_DIV*2};
    @(negedge clk);
    b_cmd_ir = 2'd2;
    b_cmd_data = rnd38();
    b_cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_cmd_valid = 1'b0;
    cur = int'({b_uir, b_cdr, b_sdr, b_udr, b_rti});
    run = 1;
    multi = 0;
    irbad = 0;
    k = 0;
    while (k < 500) begin
      @(negedge clk);
      k++;
      if (b_rsp_valid) break;
      code = int'({b_uir, b_cdr, b_sdr, b_udr, b_rti});
      if ($countones(code) > 1) multi = 1;
      if (b_ir !== 2'd2) irbad = 1;
      if (code == cur) run++;
      else begin
        obs_code.push_back(cur);
        obs_len.push_back(run);
        cur = code;
        run = 1;
      end
    end
    obs_code.push_back(cur);
    obs_len.push_back(run);
    n_chk++;
    if (obs_code.size() != exp_code.size()) begin
      n_fail++;
      $display("FAIL strobe_runs got %0d want %0d",
               obs_code.size(), exp_code.size());
    end else begin
      for (int i = 0; i < exp_code.size(); i++) begin
        n_chk++;
        if (obs_code[i] != exp_code[i] ||
            obs_len[i] != exp_len[i]) begin
          n_fail++;
          $display("FAIL strobe_run%0d got %b x%0d want %b x%0d",
                   i, obs_code[i][4:0], obs_len[i],
                   exp_code[i][4:0], exp_len[i]);
        end
      end
    end
    n_chk++;
    if (multi) begin
      n_fail++;
      $display("FAIL strobe_onehot got overlap want none");
    end
    n_chk++;
    if (irbad) begin
      n_fail++;
      $display("FAIL strobe_ir got not-2 want 2");
    end
    @(negedge clk);
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [37:0] d1, d2, held;
    logic [1:0]  ir2;
    int lat;
    d1 = rnd38();
    d2 = rnd38();
    ir2 = 2'($urandom_range(3));
    load_tgt(rnd38());
    a_run(2'd1, d1, lat);
    held = a_rsp_data;
    a_cmd_ir = ir2;
    a_cmd_data = d2;
    a_cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (a_cmd_ready !== 1'b0 || a_rsp_data !== held ||
          a_rsp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_hold%0d got r=%b v=%b d=%h want 0/1/%h",
                 i, a_cmd_ready, a_rsp_valid, a_rsp_data, held);
      end
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    n_chk++;
    if (a_rsp_valid !== 1'b0 || a_cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_handshake got v=%b r=%b want 0/1",
               a_rsp_valid, a_cmd_ready);
    end
    @(negedge clk);
    a_cmd_valid = 1'b0;
    n_chk++;
    if (a_cmd_ready !== 1'b0 || a_ir !== ir2) begin
      n_fail++;
      $display("FAIL b2b_accept got r=%b ir=%0d want 0/%0d",
               a_cmd_ready, a_ir, ir2);
    end
    lat = 0;
    while (!a_rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat != A_LAT) begin
      n_fail++;
      $display("FAIL b2b_latency got %0d want %0d", lat, A_LAT);
    end
    n_chk++;
    if (a_rsp_data !== d1) begin
      n_fail++;
      $display("FAIL b2b_rsp got %h want %h", a_rsp_data, d1);
    end
    a_ack();
  endtask

  task automatic test_reset_mid();
    int rises, k;
    logic pt;
    bit saw_udr, saw_rsp;
    load_tgt(rnd38());
    @(negedge clk);
    a_cmd_ir = 2'd3;
    a_cmd_data = rnd38();
    a_cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_cmd_valid = 1'b0;
    rises = 0;
    pt = a_tck;
    k = 0;
    while (rises < 20 && k < 1000) begin
      @(negedge clk);
      k++;
      if (a_sdr && a_tck && !pt) rises++;
      pt = a_tck;
    end
    n_chk++;
    if (rises != 20) begin
      n_fail++;
      $display("FAIL abort_reach got %0d rises want 20", rises);
    end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (a_tck !== 1'b0 ||
        {a_uir, a_cdr, a_sdr, a_udr, a_rti} !== 5'd0 ||
        a_cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state got tck=%b s=%b r=%b want 0/0/1",
               a_tck, {a_uir, a_cdr, a_sdr, a_udr, a_rti},
               a_cmd_ready);
    end
    reset = 1'b0;
    saw_udr = 0;
    saw_rsp = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (a_udr) saw_udr = 1;
      if (a_rsp_valid) saw_rsp = 1;
    end
    n_chk++;
    if (saw_udr || saw_rsp) begin
      n_fail++;
      $display("FAIL abort_quiet got udr=%b rsp=%b want 0/0",
               saw_udr, saw_rsp);
    end
  endtask

  task automatic test_dr1();
    int lat;
    @(negedge clk);
    c_cmd_ir = 2'($urandom_range(3));
    c_cmd_data = 1'b0;
    c_cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c_cmd_valid = 1'b0;
    lat = 0;
    while (!c_rsp_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat != 31) begin
      n_fail++;
      $display("FAIL dr1_latency got %0d want 31", lat);
    end
    n_chk++;
    if (c_rsp_data !== 1'b1) begin
      n_fail++;
      $display("FAIL dr1_rsp got %b want 1", c_rsp_data);
    end
    @(negedge clk);
    c_rsp_ready = 1'b1;
    @(negedge clk);
    c_rsp_ready = 1'b0;
    n_chk++;
    if (c_cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dr1_ready got %b want 1", c_cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_strobes();
    test_back_to_back();
    test_reset_mid();
    test_dr1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
